ws2811_frame_scheduler: RTL and testbench
=========================================

WS2811_FRAME_SCHEDULER -- requirements
Module: ws2811_frame_scheduler

Interface
REQ-001 Parameter NUM_LEDS, default 60: pixels per frame, range 1..256.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles to wait for source data, range 1..255.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 frame_tick  in  1  one-cycle pulse requesting a new frame.
REQ-006 a_req / b_req  in  1 each  source A / B requests ownership of the next frame.
REQ-007 a_valid / b_valid  in  1 each  source A / B pixel data valid.
REQ-008 a_red, a_green, a_blue, b_red, b_green, b_blue  in  8 each  source pixel colour.
REQ-009 drv_addr  in  8  pixel address currently requested by the WS2811 driver.
REQ-010 pix_addr  out  8  pixel address presented to the granted source.
REQ-011 a_rd / b_rd  out  1 each  one-cycle read strobe to source A / B.
REQ-012 drv_red, drv_green, drv_blue  out  8 each  colour presented to the driver.
REQ-013 grant_a / grant_b  out  1 each  frame ownership; never both high.
REQ-014 busy  out  1  high while a frame is owned.
REQ-015 frame_done  out  1  one-cycle pulse at frame completion.
REQ-016 timeout_err  out  1  one-cycle pulse when a fetch times out.

Function
REQ-017 States: IDLE, ARB, FETCH, WAIT, HOLD.
REQ-018 IDLE: frame_tick=1 -> ARB; frame_tick is ignored in every other state (no queuing).
REQ-019 ARB (1 cycle): no request -> IDLE, no grant, no frame_done; exactly one request -> grant it; both requests -> grant the source not granted last, with A winning after reset.
REQ-020 The grant and busy assert on the ARB->HOLD edge and remain stable until frame end; a_req/b_req changes mid-frame have no effect.
REQ-021 HOLD: drv_addr != last_addr -> FETCH; last_addr resets to 8'hFF, so the first pixel always fetches.
REQ-022 FETCH (1 cycle): pix_addr <= drv_addr; pulse the granted source's rd strobe; last_addr <= drv_addr; clear the wait counter -> WAIT.
REQ-023 WAIT: granted valid=1 -> latch that source's colour into drv_* the same edge; pixel count +1 -> HOLD.
REQ-024 WAIT: the valid of the non-granted source is ignored.
REQ-025 WAIT: the counter reaches TIMEOUT cycles with no valid -> drv_* <= 0 (black), timeout_err pulse, pixel count +1 -> HOLD.
REQ-026 The pixel count is 9 bits; when it reaches NUM_LEDS on a WAIT exit, the next state is IDLE with frame_done pulsed, grants and busy dropped, pixel count cleared, and last_addr <= 8'hFF, all on the same edge.
REQ-027 drv_addr changes during WAIT are not aborted; the new address is detected in HOLD after completion.
REQ-028 Valid and timeout in the same cycle: valid wins, with no timeout_err.
REQ-029 IDLE/ARB: drv_* hold their last latched value.
REQ-030 Fetch latency: rd strobe 1 cycle after the address change is registered in HOLD; drv_* update on the valid edge.

Reset
REQ-031 While reset is high, the following are held at 0: all outputs, state = IDLE, pixel count, and wait counter; last_addr = 8'hFF; round-robin pointer = "A next".
REQ-032 Reset mid-frame abandons the frame: no frame_done, and outputs are cleared asynchronously.

Verification
REQ-033 a_req=1, frame_tick, NUM_LEDS=4, drv_addr 0..3, a_valid 2 cycles after each a_rd with colour (addr,0,0) -> grant_a only; drv_red=0,1,2,3 in turn; frame_done exactly once after the 4th latch.
REQ-034 a_req=b_req=1 over three frames -> grants A, B, A.
REQ-035 Granted B never asserts valid, TIMEOUT=15 -> b_rd, then timeout_err 15 cycles later; drv_*=0; the frame advances to the next pixel.
REQ-036 b_valid pulses while A is granted and a_valid is timed together with the TIMEOUT cycle -> B's data is ignored; A's colour is latched with no timeout_err.
REQ-037 frame_tick during HOLD and reset asserted mid-WAIT -> no second frame; after reset: IDLE, all outputs 0, next contested grant goes to A.
REQ-038 frame_tick with no requests -> ARB back to IDLE with no grant and no frame_done.

Source files
------------

// File: rtl/ws2811_frame_scheduler.sv
// rtl/ws2811_frame_scheduler.sv - arbitrates frame ownership between two pixel sources and fetches colours for a WS2811 driver
module ws2811_frame_scheduler #(
    parameter int NUM_LEDS = 60,
    parameter int TIMEOUT  = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       a_req,
    input  logic       b_req,
    input  logic       a_valid,
    input  logic       b_valid,
    input  logic [7:0] a_red,
    input  logic [7:0] a_green,
    input  logic [7:0] a_blue,
    input  logic [7:0] b_red,
    input  logic [7:0] b_green,
    input  logic [7:0] b_blue,
    input  logic [7:0] drv_addr,
    output logic [7:0] pix_addr,
    output logic       a_rd,
    output logic       b_rd,
    output logic [7:0] drv_red,
    output logic [7:0] drv_green,
    output logic [7:0] drv_blue,
    output logic       grant_a,
    output logic       grant_b,
    output logic       busy,
    output logic       frame_done,
    output logic       timeout_err
);
    localparam logic [8:0] LAST_PIX  = 9'(NUM_LEDS);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_FETCH, S_WAIT, S_HOLD} state_t;

    state_t     state_q;
    logic [7:0] pix_addr_q, last_addr_q, wait_cnt_q;
    logic [7:0] drv_red_q, drv_green_q, drv_blue_q;
    logic [8:0] pix_cnt_q;
    logic       a_rd_q, b_rd_q, grant_a_q, grant_b_q, busy_q;
    logic       frame_done_q, timeout_err_q, last_b_q;

    logic       src_valid, timed_out, frame_end;
    logic [7:0] src_red, src_green, src_blue;

    // Only the granted source is listened to; the other valid is masked off.
    assign src_valid = grant_a_q ? a_valid : (grant_b_q & b_valid);
    assign src_red   = grant_a_q ? a_red   : b_red;
    assign src_green = grant_a_q ? a_green : b_green;
    assign src_blue  = grant_a_q ? a_blue  : b_blue;
    assign timed_out = (wait_cnt_q == WAIT_LAST);
    assign frame_end = ((pix_cnt_q + 9'd1) == LAST_PIX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pix_addr_q    <= 8'd0;
            last_addr_q   <= 8'hFF;
            wait_cnt_q    <= 8'd0;
            pix_cnt_q     <= 9'd0;
            drv_red_q     <= 8'd0;
            drv_green_q   <= 8'd0;
            drv_blue_q    <= 8'd0;
            a_rd_q        <= 1'b0;
            b_rd_q        <= 1'b0;
            grant_a_q     <= 1'b0;
            grant_b_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            last_b_q      <= 1'b1;
        end else begin
            a_rd_q        <= 1'b0;
            b_rd_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                S_IDLE: if (frame_tick) state_q <= S_ARB;
                S_ARB: begin
                    // On contention the source not granted last wins.
                    if (a_req && (!b_req || last_b_q)) begin
                        grant_a_q <= 1'b1;
                        busy_q    <= 1'b1;
                        last_b_q  <= 1'b0;
                        state_q   <= S_HOLD;
                    end else if (b_req) begin
                        grant_b_q <= 1'b1;
                        busy_q    <= 1'b1;
                        last_b_q  <= 1'b1;
                        state_q   <= S_HOLD;
                    end else begin
                        state_q   <= S_IDLE;
                    end
                end
                S_HOLD: if (drv_addr != last_addr_q) state_q <= S_FETCH;
                S_FETCH: begin
                    pix_addr_q  <= drv_addr;
                    last_addr_q <= drv_addr;
                    a_rd_q      <= grant_a_q;
                    b_rd_q      <= grant_b_q;
                    wait_cnt_q  <= 8'd0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    if (src_valid || timed_out) begin
                        drv_red_q     <= src_valid ? src_red   : 8'd0;
                        drv_green_q   <= src_valid ? src_green : 8'd0;
                        drv_blue_q    <= src_valid ? src_blue  : 8'd0;
                        timeout_err_q <= !src_valid;
                        if (frame_end) begin
                            frame_done_q <= 1'b1;
                            grant_a_q    <= 1'b0;
                            grant_b_q    <= 1'b0;
                            busy_q       <= 1'b0;
                            pix_cnt_q    <= 9'd0;
                            last_addr_q  <= 8'hFF;
                            state_q      <= S_IDLE;
                        end else begin
                            pix_cnt_q    <= pix_cnt_q + 9'd1;
                            state_q      <= S_HOLD;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pix_addr    = pix_addr_q;
    assign a_rd        = a_rd_q;
    assign b_rd        = b_rd_q;
    assign drv_red     = drv_red_q;
    assign drv_green   = drv_green_q;
    assign drv_blue    = drv_blue_q;
    assign grant_a     = grant_a_q;
    assign grant_b     = grant_b_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_ws2811_frame_scheduler.sv
// tb/tb_ws2811_frame_scheduler.sv - directed bench for ws2811_frame_scheduler (NUM_LEDS=4, TIMEOUT=15)
module tb_ws2811_frame_scheduler;
    logic       clk = 1'b0;
    logic       reset, frame_tick, a_req, b_req, a_valid, b_valid;
    logic [7:0] a_red, a_green, a_blue, b_red, b_green, b_blue, drv_addr;
    logic [7:0] pix_addr, drv_red, drv_green, drv_blue;
    logic       a_rd, b_rd, grant_a, grant_b, busy, frame_done, timeout_err;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int te_cnt = 0;
    int dual   = 0;

    ws2811_frame_scheduler #(.NUM_LEDS(4), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .a_req(a_req), .b_req(b_req), .a_valid(a_valid), .b_valid(b_valid),
        .a_red(a_red), .a_green(a_green), .a_blue(a_blue),
        .b_red(b_red), .b_green(b_green), .b_blue(b_blue),
        .drv_addr(drv_addr), .pix_addr(pix_addr), .a_rd(a_rd), .b_rd(b_rd),
        .drv_red(drv_red), .drv_green(drv_green), .drv_blue(drv_blue),
        .grant_a(grant_a), .grant_b(grant_b), .busy(busy),
        .frame_done(frame_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done) fd_cnt++;
        if (timeout_err) te_cnt++;
        if (grant_a && grant_b) dual++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
    endtask

    // Present an address in HOLD, wait for the read strobe, answer after 'delay' cycles.
    task automatic serve(input logic use_b, input logic [7:0] addr, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b, input int delay, output logic got);
        drv_addr = addr;
        got = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (use_b ? b_rd : a_rd) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) return;
        repeat (delay) tick();
        if (use_b) begin
            b_valid = 1'b1; b_red = r; b_green = g; b_blue = b;
        end else begin
            a_valid = 1'b1; a_red = r; a_green = g; a_blue = b;
        end
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_tick = 0; a_req = 0; b_req = 0; a_valid = 0; b_valid = 0;
        a_red = 0; a_green = 0; a_blue = 0; b_red = 0; b_green = 0; b_blue = 0; drv_addr = 0;
        tick(); tick();
        checks++;
        if ({grant_a, grant_b, busy, frame_done, timeout_err, a_rd, b_rd} !== 7'd0) begin
            $display("FAIL reset_ctrl got %b exp 0", {grant_a, grant_b, busy, frame_done, timeout_err, a_rd, b_rd});
            errors++;
        end
        checks++;
        if ({pix_addr, drv_red, drv_green, drv_blue} !== 32'd0) begin
            $display("FAIL reset_data got %h exp 0", {pix_addr, drv_red, drv_green, drv_blue});
            errors++;
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_frame_a();
        logic got;
        int fd0;
        a_req = 1'b1; b_req = 1'b0;
        fd0 = fd_cnt;
        start_frame();
        checks++;
        if ({grant_a, grant_b, busy} !== 3'b101) begin
            $display("FAIL frame_a_grant got %b exp 101", {grant_a, grant_b, busy});
            errors++;
        end
        for (int i = 0; i < 4; i++) begin
            serve(1'b0, 8'(i), 8'(i), 8'd0, 8'd0, 2, got);
            checks++;
            if (got !== 1'b1) begin
                $display("FAIL frame_a_rd pixel %0d got %b exp 1", i, got);
                errors++;
            end
            checks++;
            if ({drv_red, drv_green, drv_blue} !== {8'(i), 16'd0}) begin
                $display("FAIL frame_a_colour pixel %0d got %h exp %h", i, {drv_red, drv_green, drv_blue}, {8'(i), 16'd0});
                errors++;
            end
        end
        checks++;
        if ({frame_done, grant_a, busy} !== 3'b100) begin
            $display("FAIL frame_a_end got %b exp 100", {frame_done, grant_a, busy});
            errors++;
        end
        repeat (3) tick();
        checks++;
        if (fd_cnt - fd0 !== 1) begin
            $display("FAIL frame_a_done_count got %0d exp 1", fd_cnt - fd0);
            errors++;
        end
        a_req = 1'b0;
    endtask

    task automatic test_no_request();
        int fd0;
        fd0 = fd_cnt;
        start_frame();
        repeat (3) tick();
        checks++;
        if ({grant_a, grant_b, busy, fd_cnt - fd0 != 0} !== 4'b0000) begin
            $display("FAIL no_request got %b exp 0000", {grant_a, grant_b, busy, fd_cnt - fd0 != 0});
            errors++;
        end
        checks++;
        if (drv_red !== 8'd3) begin
            $display("FAIL no_request_hold got %0d exp 3", drv_red);
            errors++;
        end
    endtask

    task automatic test_round_robin();
        logic got;
        logic exp_a;
        reset = 1'b1; tick(); reset = 1'b0; tick();
        a_req = 1'b1; b_req = 1'b1;
        for (int f = 0; f < 3; f++) begin
            exp_a = (f != 1);
            start_frame();
            checks++;
            if ({grant_a, grant_b} !== {exp_a, ~exp_a}) begin
                $display("FAIL round_robin frame %0d got %b exp %b", f, {grant_a, grant_b}, {exp_a, ~exp_a});
                errors++;
            end
            for (int p = 0; p < 4; p++) serve(~exp_a, 8'(p), 8'(8'h10 + p), 8'h20, 8'h30, 1, got);
            checks++;
            if (busy !== 1'b0) begin
                $display("FAIL round_robin_end frame %0d got busy %b exp 0", f, busy);
                errors++;
            end
            tick();
        end
        a_req = 1'b0; b_req = 1'b0;
    endtask

    task automatic test_timeout();
        logic got;
        int k_seen;
        b_req = 1'b1;
        start_frame();
        b_req = 1'b0;
        drv_addr = 8'd0;
        got = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (b_rd) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (got !== 1'b1) begin
            $display("FAIL timeout_rd got %b exp 1", got);
            errors++;
        end
        k_seen = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (timeout_err) begin
                k_seen = k;
                break;
            end
        end
        checks++;
        if (k_seen !== 15) begin
            $display("FAIL timeout_latency got %0d exp 15", k_seen);
            errors++;
        end
        checks++;
        if ({drv_red, drv_green, drv_blue} !== 24'd0) begin
            $display("FAIL timeout_black got %h exp 0", {drv_red, drv_green, drv_blue});
            errors++;
        end
        serve(1'b1, 8'd1, 8'h44, 8'h55, 8'h66, 0, got);
        checks++;
        if ({got, drv_red, drv_green, drv_blue} !== {1'b1, 24'h445566}) begin
            $display("FAIL timeout_advance got %h exp 1445566", {got, drv_red, drv_green, drv_blue});
            errors++;
        end
        serve(1'b1, 8'd2, 8'h01, 8'h02, 8'h03, 0, got);
        serve(1'b1, 8'd3, 8'h04, 8'h05, 8'h06, 0, got);
        checks++;
        if (frame_done !== 1'b1) begin
            $display("FAIL timeout_frame_done got %b exp 1", frame_done);
            errors++;
        end
        tick();
    endtask

    task automatic test_ignore_b();
        logic got;
        a_req = 1'b1;
        start_frame();
        a_req = 1'b0;
        drv_addr = 8'd0;
        got = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (a_rd) begin
                got = 1'b1;
                break;
            end
        end
        b_red = 8'hFF; b_green = 8'hFF; b_blue = 8'hFF;
        for (int k = 0; k < 14; k++) begin
            b_valid = (k % 2 == 0);
            tick();
        end
        b_valid = 1'b0;
        a_valid = 1'b1; a_red = 8'h5A; a_green = 8'hC3; a_blue = 8'h81;
        tick();
        a_valid = 1'b0;
        checks++;
        if ({got, drv_red, drv_green, drv_blue} !== {1'b1, 24'h5AC381}) begin
            $display("FAIL ignore_b_colour got %h exp 15ac381", {got, drv_red, drv_green, drv_blue});
            errors++;
        end
        checks++;
        if (timeout_err !== 1'b0) begin
            $display("FAIL valid_beats_timeout got %b exp 0", timeout_err);
            errors++;
        end
        for (int p = 1; p < 4; p++) serve(1'b0, 8'(p), 8'h11, 8'h22, 8'h33, 0, got);
        tick();
    endtask

    task automatic test_tick_and_reset();
        logic got;
        int fd0;
        a_req = 1'b1;
        fd0 = fd_cnt;
        start_frame();
        serve(1'b0, 8'd0, 8'h21, 8'h22, 8'h23, 0, got);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        for (int p = 1; p < 4; p++) serve(1'b0, 8'(p), 8'h31, 8'h32, 8'h33, 0, got);
        repeat (5) tick();
        checks++;
        if ({busy, grant_a, fd_cnt - fd0 == 1} !== 3'b001) begin
            $display("FAIL tick_ignored got %b exp 001", {busy, grant_a, fd_cnt - fd0 == 1});
            errors++;
        end
        fd0 = fd_cnt;
        start_frame();
        drv_addr = 8'd2;
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({grant_a, grant_b, busy, frame_done, timeout_err, a_rd, b_rd, pix_addr, drv_red, drv_green, drv_blue} !== 39'd0) begin
            $display("FAIL async_reset got %h exp 0", {grant_a, grant_b, busy, frame_done, timeout_err, a_rd, b_rd, pix_addr, drv_red, drv_green, drv_blue});
            errors++;
        end
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({busy, fd_cnt - fd0 != 0} !== 2'b00) begin
            $display("FAIL reset_abandon got %b exp 00", {busy, fd_cnt - fd0 != 0});
            errors++;
        end
        b_req = 1'b1;
        start_frame();
        checks++;
        if ({grant_a, grant_b} !== 2'b10) begin
            $display("FAIL reset_rr_pointer got %b exp 10", {grant_a, grant_b});
            errors++;
        end
        a_req = 1'b0; b_req = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_frame_a();
        test_no_request();
        test_round_robin();
        test_timeout();
        test_ignore_b();
        test_tick_and_reset();
        checks++;
        if (dual !== 0) begin
            $display("FAIL dual_grant got %0d exp 0", dual);
            errors++;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
